// File: rtl/if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe_reg
// Description : IF/ID pipeline register. A main entry drives the decode-stage
//               outputs and a skid entry absorbs one extra instruction when
//               decode stalls. in_ready comes only from registered state, so
//               there is no combinational path from id_ready back into fetch.
//               Flush clears everything. A 32-bit counter tracks deliveries.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTN = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] inp_instn,
    input  logic [XLEN-1:0] pc_to_branch,
    input  logic [XLEN-1:0] nextpc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instn,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_nextpc,
    output logic [31:0]     deliver_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_NOP = NOP_INSTN[XLEN-1:0];

    state_t          state_q, state_d;
    logic [XLEN-1:0] main_instn_q, main_instn_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [XLEN-1:0] main_nextpc_q, main_nextpc_d;
    logic [XLEN-1:0] skid_instn_q, skid_instn_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_nextpc_q, skid_nextpc_d;
    logic [31:0]     count_q, count_d;

    logic w_acc_in;
    logic w_acc_out;

    assign in_ready      = (state_q != S_FULL);
    assign id_valid      = (state_q != S_EMPTY);
    assign id_instn      = main_instn_q;
    assign id_pc         = main_pc_q;
    assign id_nextpc     = main_nextpc_q;
    assign deliver_count = count_q;

    assign w_acc_in  = in_valid & in_ready;
    assign w_acc_out = id_valid & id_ready;

    // Next-state, entry movement and delivery counting.
    always_comb begin
        state_d       = state_q;
        main_instn_d  = main_instn_q;
        main_pc_d     = main_pc_q;
        main_nextpc_d = main_nextpc_q;
        skid_instn_d  = skid_instn_q;
        skid_pc_d     = skid_pc_q;
        skid_nextpc_d = skid_nextpc_q;
        count_d       = count_q;

        if (flush) begin
            // Redirect: drop held entries and this cycle's input, no delivery.
            state_d       = S_EMPTY;
            main_instn_d  = C_NOP;
            main_pc_d     = '0;
            main_nextpc_d = '0;
            skid_instn_d  = '0;
            skid_pc_d     = '0;
            skid_nextpc_d = '0;
        end else begin
            if (w_acc_out) begin
                count_d = count_q + 32'd1;
            end
            case (state_q)
                S_EMPTY: begin
                    if (w_acc_in) begin
                        state_d       = S_ONE;
                        main_instn_d  = inp_instn;
                        main_pc_d     = pc_to_branch;
                        main_nextpc_d = nextpc;
                    end
                end
                S_ONE: begin
                    if (w_acc_in && w_acc_out) begin
                        main_instn_d  = inp_instn;
                        main_pc_d     = pc_to_branch;
                        main_nextpc_d = nextpc;
                    end else if (w_acc_in) begin
                        state_d       = S_FULL;
                        skid_instn_d  = inp_instn;
                        skid_pc_d     = pc_to_branch;
                        skid_nextpc_d = nextpc;
                    end else if (w_acc_out) begin
                        // PC fields keep their last values; only the word reverts.
                        state_d      = S_EMPTY;
                        main_instn_d = C_NOP;
                    end
                end
                S_FULL: begin
                    if (w_acc_out) begin
                        state_d       = S_ONE;
                        main_instn_d  = skid_instn_q;
                        main_pc_d     = skid_pc_q;
                        main_nextpc_d = skid_nextpc_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_EMPTY;
            main_instn_q  <= C_NOP;
            main_pc_q     <= '0;
            main_nextpc_q <= '0;
            skid_instn_q  <= '0;
            skid_pc_q     <= '0;
            skid_nextpc_q <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            main_instn_q  <= main_instn_d;
            main_pc_q     <= main_pc_d;
            main_nextpc_q <= main_nextpc_d;
            skid_instn_q  <= skid_instn_d;
            skid_pc_q     <= skid_pc_d;
            skid_nextpc_q <= skid_nextpc_d;
            count_q       <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_pipe_reg
// Description : Directed vector bench for the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_reg;

    localparam logic [31:0] C_NOP = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] inp_instn;
    logic [31:0] pc_to_branch;
    logic [31:0] nextpc;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instn;
    logic [31:0] id_pc;
    logic [31:0] id_nextpc;
    logic [31:0] deliver_count;

    int n_tests;
    int n_fail;

    if_id_pipe_reg #(
        .XLEN      (32),
        .NOP_INSTN (C_NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inp_instn     (inp_instn),
        .pc_to_branch  (pc_to_branch),
        .nextpc        (nextpc),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instn      (id_instn),
        .id_pc         (id_pc),
        .id_nextpc     (id_nextpc),
        .deliver_count (deliver_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        idr;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_instn;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [0:31];
    int   nvec;

    // Distinct instruction word derived from a PC.
    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'hA5A5_0000 + pc;
    endfunction

    task automatic add(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic idr,
                       input logic ev, input logic er, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] en,
                       input logic [31:0] ec);
        vecs[nvec].rst     = rst;
        vecs[nvec].fl      = fl;
        vecs[nvec].iv      = iv;
        vecs[nvec].pc      = pc;
        vecs[nvec].idr     = idr;
        vecs[nvec].e_valid = ev;
        vecs[nvec].e_ready = er;
        vecs[nvec].e_instn = ei;
        vecs[nvec].e_pc    = ep;
        vecs[nvec].e_npc   = en;
        vecs[nvec].e_cnt   = ec;
        nvec++;
    endtask

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic er,
                             input logic [31:0] ei, input logic [31:0] ep,
                             input logic [31:0] en, input logic [31:0] ec);
        cmp({tag, ".id_valid"},      {31'd0, id_valid}, {31'd0, ev});
        cmp({tag, ".in_ready"},      {31'd0, in_ready}, {31'd0, er});
        cmp({tag, ".id_instn"},      id_instn, ei);
        cmp({tag, ".id_pc"},         id_pc, ep);
        cmp({tag, ".id_nextpc"},     id_nextpc, en);
        cmp({tag, ".deliver_count"}, deliver_count, ec);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] instn, input logic [31:0] pc,
                        input logic idr);
        reset        = rst;
        flush        = fl;
        in_valid     = iv;
        inp_instn    = instn;
        pc_to_branch = pc;
        nextpc       = pc + 32'd4;
        id_ready     = idr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nvec    = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; id_ready = 1'b0;
        inp_instn = '0; pc_to_branch = '0; nextpc = '0;

        //   rst fl iv pc     idr  valid rdy instn      pc     npc    cnt
        add(1, 0, 0, 32'h00, 0,   0, 1, C_NOP,     32'h00, 32'h00, 0); // reset
        add(0, 0, 0, 32'h00, 0,   0, 1, C_NOP,     32'h00, 32'h00, 0); // after reset
        add(0, 0, 1, 32'h00, 1,   1, 1, iw(32'h00), 32'h00, 32'h04, 0); // stream
        add(0, 0, 1, 32'h04, 1,   1, 1, iw(32'h04), 32'h04, 32'h08, 1);
        add(0, 0, 1, 32'h08, 1,   1, 1, iw(32'h08), 32'h08, 32'h0C, 2);
        add(0, 0, 1, 32'h0C, 1,   1, 1, iw(32'h0C), 32'h0C, 32'h10, 3);
        add(0, 0, 0, 32'h00, 1,   0, 1, C_NOP,     32'h0C, 32'h10, 4); // drain
        add(0, 0, 1, 32'h10, 0,   1, 1, iw(32'h10), 32'h10, 32'h14, 4); // fill
        add(0, 0, 1, 32'h14, 0,   1, 0, iw(32'h10), 32'h10, 32'h14, 4); // FULL
        add(0, 0, 0, 32'h00, 0,   1, 0, iw(32'h10), 32'h10, 32'h14, 4); // stable
        add(0, 0, 0, 32'h00, 1,   1, 1, iw(32'h14), 32'h14, 32'h18, 5); // skid->main
        add(0, 0, 0, 32'h00, 1,   0, 1, C_NOP,     32'h14, 32'h18, 6);
        add(0, 0, 1, 32'h20, 0,   1, 1, iw(32'h20), 32'h20, 32'h24, 6); // flush setup
        add(0, 0, 1, 32'h24, 0,   1, 0, iw(32'h20), 32'h20, 32'h24, 6);
        add(0, 1, 1, 32'h28, 1,   0, 1, C_NOP,     32'h00, 32'h00, 6); // flush in FULL
        add(0, 0, 0, 32'h00, 1,   0, 1, C_NOP,     32'h00, 32'h00, 6);
        add(0, 0, 1, 32'h30, 0,   1, 1, iw(32'h30), 32'h30, 32'h34, 6); // reset setup
        add(0, 0, 1, 32'h34, 0,   1, 0, iw(32'h30), 32'h30, 32'h34, 6);
        add(1, 0, 0, 32'h00, 0,   0, 1, C_NOP,     32'h00, 32'h00, 0); // reset in FULL
        add(0, 0, 1, 32'h40, 0,   1, 1, iw(32'h40), 32'h40, 32'h44, 0);
        add(0, 0, 0, 32'h00, 1,   0, 1, C_NOP,     32'h40, 32'h44, 1);
        add(0, 0, 0, 32'h00, 1,   0, 1, C_NOP,     32'h40, 32'h44, 1); // 0x40 alone

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, iw(vecs[i].pc),
                 vecs[i].pc, vecs[i].idr);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                      vecs[i].e_instn, vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_cnt);
        end

        // Input presented while in_ready=0 must not be captured, even if it changes.
        step(0, 0, 1, iw(32'h50), 32'h50, 0);
        step(0, 0, 1, iw(32'h54), 32'h54, 0);
        check_all("hold.full", 1'b1, 1'b0, iw(32'h50), 32'h50, 32'h54, 1);
        step(0, 0, 1, 32'hDEAD_0001, 32'h58, 0);
        check_all("hold.chg1", 1'b1, 1'b0, iw(32'h50), 32'h50, 32'h54, 1);
        step(0, 0, 1, 32'hBEEF_0002, 32'h5C, 1);
        check_all("hold.drain1", 1'b1, 1'b1, iw(32'h54), 32'h54, 32'h58, 2);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check_all("hold.drain2", 1'b0, 1'b1, C_NOP, 32'h54, 32'h58, 3);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check_all("hold.idle", 1'b0, 1'b1, C_NOP, 32'h54, 32'h58, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage.
- Captures the fetched instruction, its PC and the sequential next PC (pc+4) from IF. Presents them to ID with a valid/ready handshake.
- A 2-entry skid buffer absorbs ID back-pressure without a combinational ready path into IF.
- Supports a flush for branch redirect and keeps a count of instructions delivered to ID.

Parameters:
- XLEN, 32, width of instruction and PC fields.
- NOP_INSTN, 32'h0000_0000, instruction word driven on id_instn when no valid entry is presented.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- inp_instn  input  XLEN  instruction word from IF.
- pc_to_branch  input  XLEN  PC of inp_instn.
- nextpc  input  XLEN  sequential next PC (pc+4) from IF.
- in_valid  input  1  IF presents a valid instruction.
- in_ready  output  1  block can accept from IF this cycle.
- flush  input  1  discard all held and incoming entries (branch taken / redirect).
- id_ready  input  1  ID consumes the presented entry this cycle.
- id_valid  output  1  id_* fields hold a valid entry.
- id_instn  output  XLEN  instruction to ID.
- id_pc  output  XLEN  PC of id_instn.
- id_nextpc  output  XLEN  pc+4 of id_instn.
- deliver_count  output  32  instructions handed to ID since reset.

Behaviour:
- Storage: main entry {instn, pc, nextpc}, which drives the id_* outputs, and skid entry of the same shape.
- States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
- Handshake terms:
  - acc_in = in_valid & in_ready.
  - acc_out = id_valid & id_ready.
- Output decode:
  - in_ready = (state != FULL), decoded from registered state only; no combinational path from id_ready or in_valid.
  - id_valid = (state != EMPTY).
- Reset, synchronous, highest priority:
  - State EMPTY; id_valid=0, in_ready=1.
  - id_instn=NOP_INSTN, id_pc=0, id_nextpc=0.
  - Skid entry cleared; deliver_count=0.
- Flush (when reset=0), overrides all other activity in that cycle:
  - Next state EMPTY; main and skid cleared as on reset.
  - Any same-cycle input is discarded.
  - deliver_count does not increment, even if id_ready=1.
- Transitions (no reset, no flush):
  - EMPTY: acc_in -> ONE, main <= input. Otherwise stay EMPTY.
  - ONE, acc_in & acc_out -> ONE, main <= input.
  - ONE, acc_in & !acc_out -> FULL, skid <= input, main held.
  - ONE, !acc_in & acc_out -> EMPTY; id_instn <= NOP_INSTN, id_pc/id_nextpc retain last values.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so acc_in is impossible. acc_out -> ONE, main <= skid. Otherwise hold.
- Ordering: strict FIFO; entries leave in arrival order, none are duplicated or dropped except by flush.
- Latency: an instruction accepted in cycle N appears on id_* with id_valid=1 in cycle N+1 when the buffer was empty or draining.
- Throughput: 1 instruction/cycle sustained while id_ready=1.
- Stability: while id_valid=1 and id_ready=0, all id_* outputs hold stable.
- deliver_count increments by 1 on acc_out & !flush & !reset; wraps modulo 2^32.
- in_valid while in_ready=0 has no effect; IF must hold its inputs.
- Input fields are stored as given; no arithmetic is done on nextpc.

Test Plan:
- Reset → id_valid=0, in_ready=1, id_instn=0, id_pc=0, deliver_count=0 on the first cycle after reset drops.
- Stream 4 instructions at PC 0,4,8,12 with id_ready=1 → each on id_* one cycle later with id_nextpc = pc+4; deliver_count=4.
- Push PC 0x10 and 0x14 with id_ready=0 → state FULL, in_ready=0, id_pc=0x10 stable. Raise id_ready → 0x10 then 0x14 delivered in order; in_ready returns to 1 one cycle after the first drain.
- In FULL state assert flush with id_ready=1 and in_valid=1 → next cycle id_valid=0, id_instn=NOP_INSTN, in_ready=1; deliver_count unchanged; the flushed-cycle input never appears.
- Assert reset in FULL state → all outputs at reset values next cycle; a following accept of PC 0x40 appears alone.
- Drive in_valid=1 while in_ready=0 with a changing inp_instn → the changed value is not captured; only the held word is delivered.
